// File: rtl/rr_grant_decoder.sv
// Grant side of a round-robin arbiter: registers a one-hot grant from the coder's winner index,
// holds it until release, and advances the priority pointer. Optional hold timeout: RR_GRANT_TIMEOUT_EN.
module rr_grant_decoder #(
  parameter int REQWIDTH = 3,
  parameter int TIMEOUT  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [2**REQWIDTH-1:0]  req_i,
  input  logic [REQWIDTH-1:0]     data_num_i,
  input  logic                    num_valid_i,
  output logic [2**REQWIDTH-1:0]  gnt_o,
  output logic [REQWIDTH-1:0]     gnt_num_o,
  output logic                    gnt_valid_o,
  output logic [REQWIDTH-1:0]     prior_o,
  output logic                    timeout_o
);

  localparam int N = 2**REQWIDTH;

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("rr_grant_decoder: TIMEOUT must be at least 2");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [N-1:0]        gnt_q, gnt_d;
  logic [REQWIDTH-1:0] gnt_num_q, gnt_num_d;
  logic [REQWIDTH-1:0] prior_q, prior_d;
  logic                timeout_q, timeout_d;

`ifdef RR_GRANT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_num_d = gnt_num_q;
    prior_d   = prior_q;
    timeout_d = 1'b0;
`ifdef RR_GRANT_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        // An index whose request bit is low is stale or inconsistent; never grant it.
        if (num_valid_i && req_i[data_num_i]) begin
          state_d   = GRANT;
          gnt_num_d = data_num_i;
          gnt_d     = N'(1) << data_num_i;
`ifdef RR_GRANT_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      GRANT: begin
        if (!req_i[gnt_num_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          prior_d = gnt_num_q + REQWIDTH'(1);
        end
`ifdef RR_GRANT_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          gnt_d     = '0;
          prior_d   = gnt_num_q + REQWIDTH'(1);
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_num_q <= '0;
      prior_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_num_q <= gnt_num_d;
      prior_q   <= prior_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef RR_GRANT_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`endif

  assign gnt_o       = gnt_q;
  assign gnt_num_o   = gnt_num_q;
  assign gnt_valid_o = |gnt_q;
  assign prior_o     = prior_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_rr_grant_decoder.sv
// Bench for rr_grant_decoder: a behavioural coder plus a reference model feed a scoreboard
// that is compared after every clock edge.
module tb_rr_grant_decoder;

  localparam int TO = 4;
`ifdef RR_GRANT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] req_i;
  logic [2:0] data_num_i;
  logic       num_valid_i;
  logic [7:0] gnt_o;
  logic [2:0] gnt_num_o;
  logic       gnt_valid_o;
  logic [2:0] prior_o;
  logic       timeout_o;

  rr_grant_decoder #(.REQWIDTH(3), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .data_num_i(data_num_i),
    .num_valid_i(num_valid_i), .gnt_o(gnt_o), .gnt_num_o(gnt_num_o),
    .gnt_valid_o(gnt_valid_o), .prior_o(prior_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] num;
    logic       valid;
    logic [2:0] prior;
    logic       to;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit       m_grant;
  bit [2:0] m_num;
  bit [2:0] m_prior;
  int       m_cnt;
  bit       m_to;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] coder(input logic [7:0] r, input logic [2:0] p);
    if (r[p]) return p;
    for (int i = 7; i >= 0; i--) if (r[i]) return 3'(i);
    return 3'd0;
  endfunction

  task automatic model_reset();
    m_grant = 0; m_num = 0; m_prior = 0; m_cnt = 0; m_to = 0;
    sb.delete();
  endtask

  task automatic step(input logic [7:0] r, input bit ovr, input logic [2:0] dn);
    exp_t e;
    @(negedge clk_i);
    req_i       = r;
    num_valid_i = ovr ? 1'b1 : |r;
    data_num_i  = ovr ? dn : coder(r, m_prior);
    m_to = 0;
    if (!m_grant) begin
      if (num_valid_i && r[data_num_i]) begin
        m_grant = 1; m_num = data_num_i; m_cnt = 0;
      end
    end else if (!r[m_num]) begin
      m_grant = 0; m_prior = m_num + 3'd1;
    end else if (TO_EN && m_cnt == TO - 1) begin
      m_grant = 0; m_prior = m_num + 3'd1; m_to = 1;
    end else begin
      m_cnt++;
    end
    e.gnt   = m_grant ? (8'h01 << m_num) : 8'h00;
    e.num   = m_num;
    e.valid = m_grant;
    e.prior = m_prior;
    e.to    = m_to;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    e = sb.pop_front();
    check("gnt_o",       32'(gnt_o),       32'(e.gnt));
    check("gnt_num_o",   32'(gnt_num_o),   32'(e.num));
    check("gnt_valid_o", 32'(gnt_valid_o), 32'(e.valid));
    check("prior_o",     32'(prior_o),     32'(e.prior));
    check("timeout_o",   32'(timeout_o),   32'(e.to));
  endtask

  initial begin
    logic [7:0] r;
    rst_i = 1'b1; req_i = '0; num_valid_i = 1'b0; data_num_i = '0;
    model_reset();
    #1;
    check("rst_gnt",   32'(gnt_o),       32'h0);
    check("rst_valid", 32'(gnt_valid_o), 32'h0);
    check("rst_prior", 32'(prior_o),     32'h0);
    check("rst_num",   32'(gnt_num_o),   32'h0);
    check("rst_to",    32'(timeout_o),   32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // single requester
    step(8'h08, 0, 0);
    check("single_gnt", 32'(gnt_o), 32'h08);
    check("single_num", 32'(gnt_num_o), 32'd3);
    step(8'h00, 0, 0);
    check("single_rel_gnt", 32'(gnt_o), 32'h00);
    check("single_rel_prior", 32'(prior_o), 32'd4);

    // hold grant 5, then asynchronous reset between edges
    step(8'h20, 0, 0);
    check("hold5_gnt", 32'(gnt_o), 32'h20);
    #2 rst_i = 1'b1;
    #1;
    check("async_rst_gnt",   32'(gnt_o),       32'h0);
    check("async_rst_valid", 32'(gnt_valid_o), 32'h0);
    check("async_rst_prior", 32'(prior_o),     32'h0);
    model_reset();
    req_i = '0; num_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;

    // rotation with all requesting, each grant held two cycles
    for (int i = 0; i < 9; i++) begin
      step(8'hFF, 0, 0);
      check("rot_order", 32'(gnt_num_o), 32'(i % 8));
      step(8'hFF, 0, 0);
      r = 8'hFF & ~(8'h01 << (i % 8));
      step(r, 0, 0);
      check("rot_idle", 32'(gnt_valid_o), 32'h0);
    end

    // wrap from 7 back to 0
    step(8'h80, 0, 0);
    check("wrap_gnt7", 32'(gnt_num_o), 32'd7);
    step(8'h01, 0, 0);
    check("wrap_prior", 32'(prior_o), 32'd0);
    step(8'h81, 0, 0);
    check("wrap_next", 32'(gnt_o), 32'h01);
    step(8'h00, 0, 0);

    // inconsistent index
    step(8'h10, 1, 3'd2);
    check("incons_gnt", 32'(gnt_o), 32'h0);
    step(8'h00, 0, 0);

    // long hold of requester 1
    if (TO_EN) begin
      for (int i = 0; i < 4; i++) begin
        step(8'h02, 0, 0);
        check("to_hold", 32'(gnt_o), 32'h02);
      end
      step(8'h02, 0, 0);
      check("to_pulse", 32'(timeout_o), 32'h1);
      check("to_gnt",   32'(gnt_o),     32'h0);
      check("to_prior", 32'(prior_o),   32'd2);
      step(8'h02, 0, 0);
      check("to_regrant", 32'(gnt_o), 32'h02);
      check("to_pulse_end", 32'(timeout_o), 32'h0);
    end else begin
      for (int i = 0; i < 10; i++) step(8'h02, 0, 0);
      check("hold_gnt", 32'(gnt_o), 32'h02);
      check("hold_to",  32'(timeout_o), 32'h0);
    end
    step(8'h00, 0, 0);
    step(8'h00, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
